// File: rtl/cs_result_fifo.sv
// cs_result_fifo: output stage of the CS block.
// It captures Y one cycle after each x_load and drops the warm-up results.
// The remaining results go into a first-word-fall-through FIFO that the consumer
// drains over valid/ready. Results lost because the FIFO was full are recorded
// in a sticky overflow flag and a saturating drop counter.
module cs_result_fifo #(
  parameter int unsigned DATA_W = 10,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned WARMUP = 8,
  parameter int unsigned DROP_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     x_load,
  input  logic [DATA_W-1:0]        y_in,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     warm,
  output logic                     overflow,
  output logic [DROP_W-1:0]        drop_cnt,
  input  logic                     ovf_clr
);

  localparam int unsigned PtrW  = $clog2(DEPTH);
  localparam int unsigned LvlW  = PtrW + 1;
  localparam int unsigned WcntW = (WARMUP > 1) ? $clog2(WARMUP) : 1;

  localparam logic [WcntW-1:0] WcntLast = WcntW'((WARMUP > 0) ? (WARMUP - 1) : 0);
  localparam logic [LvlW-1:0]  LvlFull  = LvlW'(DEPTH);
  localparam logic [PtrW-1:0]  PtrLast  = PtrW'(DEPTH - 1);

  typedef enum logic [0:0] {StDiscard, StStream} state_e;

  // With no warm-up there is nothing to discard, so reset straight into streaming.
  localparam state_e StReset = (WARMUP == 0) ? StStream : StDiscard;

  state_e              state_q, state_d;
  logic [WcntW-1:0]    wcnt_q, wcnt_d;
  logic                y_stb_q;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]     level_q, level_d;
  logic                overflow_q, overflow_d;
  logic [DROP_W-1:0]   drop_cnt_q, drop_cnt_d;

  logic stream;
  logic full;
  logic pop;
  logic push_req;
  logic push;
  logic drop;

  // Handshake and push/drop decode.
  always_comb begin
    stream   = (state_q == StStream);
    full     = (level_q == LvlFull);
    pop      = out_valid & out_ready;
    push_req = stream & y_stb_q;
    // A full FIFO still accepts a result when a word leaves in the same cycle.
    push     = push_req & (~full | pop);
    drop     = push_req & full & ~pop;
  end

  // Warm-up sequencing: count discarded results, then stream until reset.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    unique case (state_q)
      StDiscard: begin
        if (y_stb_q) begin
          wcnt_d = wcnt_q + 1'b1;
          if (wcnt_q == WcntLast) begin
            state_d = StStream;
          end
        end
      end
      StStream: begin
        state_d = StStream;
      end
      default: begin
        state_d = StReset;
      end
    endcase
  end

  // Pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + 1'b1;
    end
    unique case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // Overflow bookkeeping: a drop in the same cycle as a clear wins.
  always_comb begin
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (drop) begin
      overflow_d = 1'b1;
      if (ovf_clr) begin
        drop_cnt_d = DROP_W'(1);
      end else if (~&drop_cnt_q) begin
        drop_cnt_d = drop_cnt_q + 1'b1;
      end
    end else if (ovf_clr) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StReset;
      wcnt_q     <= '0;
      y_stb_q    <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      y_stb_q    <= x_load;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Storage array; contents are meaningless while level is zero, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= y_in;
    end
  end

  // Output drive: the head word falls through, and reads as zero when empty.
  always_comb begin
    out_valid = (level_q != '0);
    out_data  = out_valid ? mem[rd_ptr_q] : '0;
    level     = level_q;
    warm      = stream;
    overflow  = overflow_q;
    drop_cnt  = drop_cnt_q;
  end

endmodule

// File: tb/tb_cs_result_fifo.sv
// Directed bench for cs_result_fifo with a small 9-tap running-sum CS model
// that supplies y_in.
module tb_cs_result_fifo;

  logic       clk;
  logic       reset;
  logic       x_load;
  logic [7:0] x;
  logic [9:0] y_in;
  logic [9:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] level;
  logic       warm;
  logic       overflow;
  logic [7:0] drop_cnt;
  logic       ovf_clr;

  logic [7:0] win [9];
  logic       tb_stb;
  logic [9:0] q [$];
  logic [9:0] front;
  int         checks;
  int         errors;
  int         got;
  int         t1_exp [4] = '{45, 54, 63, 72};

  cs_result_fifo #(
    .DATA_W (10),
    .DEPTH  (16),
    .WARMUP (8),
    .DROP_W (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .x_load    (x_load),
    .y_in      (y_in),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .level     (level),
    .warm      (warm),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt),
    .ovf_clr   (ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // CS model: X is registered into a 9-sample window; Y is the window sum.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 9; i++) win[i] <= 8'd0;
      tb_stb <= 1'b0;
    end else begin
      tb_stb <= x_load;
      if (x_load) begin
        win[0] <= x;
        for (int i = 1; i < 9; i++) win[i] <= win[i-1];
      end
    end
  end

  always_comb begin
    y_in = '0;
    for (int i = 0; i < 9; i++) y_in = y_in + 10'(win[i]);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    x_load    = 1'b0;
    x         = 8'd0;
    out_ready = 1'b0;
    ovf_clr   = 1'b0;
    tick();
    tick();
    check("rst_valid", 32'(out_valid), 0);
    check("rst_data", 32'(out_data), 0);
    check("rst_level", 32'(level), 0);
    check("rst_warm", 32'(warm), 0);
    check("rst_ovf", 32'(overflow), 0);
    check("rst_drops", 32'(drop_cnt), 0);
    reset = 1'b0;

    // 1: X=1..12, first 8 results discarded, 4 sums emerge in order.
    out_ready = 1'b1;
    got = 0;
    for (int i = 1; i <= 16; i++) begin
      x_load = (i <= 12);
      x      = 8'(i);
      tick();
      if (i == 8) check("t1_warm_low", 32'(warm), 0);
      if (i == 9) check("t1_warm_high", 32'(warm), 1);
      if (out_valid) begin
        if (got < 4) check("t1_data", 32'(out_data), 32'(t1_exp[got]));
        got++;
      end
    end
    check("t1_count", 32'(got), 4);

    // 2: fill with X=100 and no consumer, then overflow.
    reset  = 1'b1;
    x_load = 1'b0;
    tick();
    reset     = 1'b0;
    out_ready = 1'b0;
    x         = 8'd100;
    for (int i = 1; i <= 41; i++) begin
      x_load = 1'b1;
      tick();
      if (i == 25) begin
        check("t2_full_level", 32'(level), 16);
        check("t2_no_ovf_yet", 32'(overflow), 0);
      end
      if (i == 26) begin
        check("t2_ovf", 32'(overflow), 1);
        check("t2_drop1", 32'(drop_cnt), 1);
      end
      if (i == 41) begin
        check("t2_drop16", 32'(drop_cnt), 16);
        check("t2_head", 32'(out_data), 900);
        check("t2_level", 32'(level), 16);
      end
    end

    // 3: full with push and pop together, then drain across the pointer wrap.
    for (int i = 0; i < 16; i++) q.push_back(10'd900);
    for (int k = 0; k < 60; k++) begin
      x_load    = (k < 20);
      x         = 8'(k + 1);
      out_ready = 1'b1;
      if (out_valid) begin
        if (q.size() == 0) begin
          check("t3_extra_word", 32'(out_valid), 0);
        end else begin
          front = q.pop_front();
          check("t3_order", 32'(out_data), 32'(front));
        end
      end
      if (tb_stb) q.push_back(y_in);
      tick();
      if (k <= 20) check("t3_level16", 32'(level), 16);
      if (k == 20) check("t3_drops_kept", 32'(drop_cnt), 16);
    end
    check("t3_drained", 32'(q.size()), 0);
    check("t3_level0", 32'(level), 0);

    // 4: sparse loads into an empty FIFO with the consumer always ready.
    out_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      x_load = ((k % 3) == 0);
      x      = 8'(k);
      tick();
      check("t4_pulse", 32'(out_valid), ((k % 3) == 1) ? 1 : 0);
      check("t4_level_le1", 32'(level <= 5'd1), 1);
    end

    // 5: reset mid-stream with five words buffered.
    out_ready = 1'b0;
    x         = 8'd5;
    for (int k = 1; k <= 6; k++) begin
      x_load = 1'b1;
      tick();
    end
    check("t5_level5", 32'(level), 5);
    reset  = 1'b1;
    x_load = 1'b0;
    tick();
    check("t5_valid", 32'(out_valid), 0);
    check("t5_level", 32'(level), 0);
    check("t5_warm", 32'(warm), 0);
    check("t5_ovf", 32'(overflow), 0);
    check("t5_drops", 32'(drop_cnt), 0);
    reset     = 1'b0;
    out_ready = 1'b1;
    x         = 8'd7;
    for (int k = 1; k <= 9; k++) begin
      x_load = 1'b1;
      tick();
      check("t5_discard", 32'(out_valid), 0);
      check("t5_warm_seq", 32'(warm), (k >= 9) ? 1 : 0);
    end
    x_load = 1'b0;
    tick();
    check("t5_first_valid", 32'(out_valid), 1);
    check("t5_first_data", 32'(out_data), 63);
    tick();
    check("t5_popped", 32'(out_valid), 0);

    // 6: clear colliding with a drop, then a clear on its own.
    out_ready = 1'b0;
    x         = 8'd1;
    for (int k = 1; k <= 19; k++) begin
      x_load = 1'b1;
      tick();
    end
    check("t6_level", 32'(level), 16);
    check("t6_head", 32'(out_data), 57);
    check("t6_drop2", 32'(drop_cnt), 2);
    x_load  = 1'b0;
    ovf_clr = 1'b1;
    tick();
    check("t6_clr_drop_ovf", 32'(overflow), 1);
    check("t6_clr_drop_cnt", 32'(drop_cnt), 1);
    tick();
    check("t6_clr_ovf", 32'(overflow), 0);
    check("t6_clr_cnt", 32'(drop_cnt), 0);
    check("t6_head_kept", 32'(out_data), 57);
    ovf_clr = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
